// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg
//   Shared definitions for the adder self-test controller:
//   - state_t     : FSM state encoding (IDLE=0, SETTLE=1, CHECK=2, DONE=3)
//   - sweep_len() : number of {b,a} vectors in an exhaustive sweep of a
//                   WIDTH-bit adder, i.e. 2^(2*WIDTH)
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int unsigned sweep_len(input int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

endpackage

// File: rtl/bist_vector_gen.sv
// bist_vector_gen
//   Vector counter and settle counter for the adder self-test.
//   Ports:
//     clk, reset : system clock, synchronous active-high reset
//     load       : start a sweep: vector <= 0, settle counter reloaded
//     advance    : step to the next vector, settle counter reloaded
//     tick       : count one settle cycle down (ignored at zero)
//     vector     : current {b,a}; a is the low WIDTH bits
//     last       : vector is the final one of the sweep (N-1)
//     settled    : settle counter has reached zero
//   load has priority over advance, advance over tick.
module bist_vector_gen
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 tick,
  output logic [2*WIDTH-1:0]   vector,
  output logic                 last,
  output logic                 settled
);

  localparam int          VW       = 2 * WIDTH;
  localparam int unsigned N        = sweep_len(WIDTH);
  localparam logic [VW-1:0] LAST_VEC = VW'(N - 1);
  localparam logic [VW-1:0] VEC_ONE  = VW'(1);
  // Counter holds SETTLE_CYCLES-1 so that a reload plus the zero cycle
  // gives exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0]  RELOAD   = 4'(SETTLE_CYCLES - 1);

  logic [3:0] settle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vector     <= '0;
      settle_cnt <= '0;
    end else if (load) begin
      vector     <= '0;
      settle_cnt <= RELOAD;
    end else if (advance) begin
      vector     <= vector + VEC_ONE;
      settle_cnt <= RELOAD;
    end else if (tick && settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  assign last    = (vector == LAST_VEC);
  assign settled = (settle_cnt == 4'd0);

endmodule

// File: rtl/adder_bist.sv
// adder_bist
//   Synthesizable exhaustive self-test for a WIDTH-bit adder (half adder
//   when WIDTH=1). Sweeps every {b,a}, holds each for SETTLE_CYCLES
//   (legal 1..15), then compares {dut_c_out,dut_sum} against a+b.
//   Ports:
//     clk, reset   : system clock, synchronous active-high reset
//     start        : one-cycle request, honoured only in IDLE or DONE;
//                    ignored while a sweep is running
//     dut_a, dut_b : registered operands to the adder under test
//     dut_sum, dut_c_out : adder results
//     busy         : sweep in progress (SETTLE or CHECK)
//     done, pass   : sweep finished / finished with no mismatch
//     err_count    : mismatching vectors in the last sweep
//     fail_valid, fail_vector : first failing {b,a} (0 when none)
//     fsm_state    : current controller state, for observation
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_c_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH-1:0]   fail_vector,
  output state_t               fsm_state
);

  localparam int             VW      = 2 * WIDTH;
  localparam logic [VW:0]    ERR_ONE = (VW + 1)'(1);

  state_t state, state_next;

  logic          load, advance, tick, check_en, clear;
  logic [VW-1:0] vector;
  logic          last, settled;
  logic [WIDTH:0] golden, observed;
  logic          mismatch;

  bist_vector_gen #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_vector_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .tick    (tick),
    .vector  (vector),
    .last    (last),
    .settled (settled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    tick       = 1'b0;
    check_en   = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          clear      = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settled) begin
          state_next = CHECK;
        end else begin
          tick = 1'b1;
        end
      end
      CHECK: begin
        check_en = 1'b1;
        if (last) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Golden result is the zero-extended WIDTH+1 bit sum of the operands.
  assign golden   = {1'b0, dut_a} + {1'b0, dut_b};
  assign observed = {dut_c_out, dut_sum};
  assign mismatch = (observed != golden);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_vector <= '0;
    end else if (check_en && mismatch) begin
      err_count <= err_count + ERR_ONE;
      if (!fail_valid) begin
        fail_valid  <= 1'b1;
        fail_vector <= vector;
      end
    end
  end

  assign dut_a     = vector[WIDTH-1:0];
  assign dut_b     = vector[VW-1:WIDTH];
  assign busy      = (state == SETTLE) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign fsm_state = state;

endmodule

// File: tb/tb_adder_bist.sv
module tb_adder_bist;
  import adder_bist_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  int   fault_mode = 0;  // 0 correct, 1 carry stuck at 0, 2 sum inverted

  // ---------------- WIDTH=1 instance ----------------
  logic       dut_a, dut_b, dut_sum, dut_c_out;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] fail_vector;
  state_t     fsm_state;

  always_comb begin
    dut_sum   = dut_a ^ dut_b;
    dut_c_out = dut_a & dut_b;
    if (fault_mode == 1) dut_c_out = 1'b0;
    if (fault_mode == 2) dut_sum = ~(dut_a ^ dut_b);
  end

  adder_bist #(.WIDTH(1), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum), .dut_c_out(dut_c_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vector(fail_vector), .fsm_state(fsm_state)
  );

  // ---------------- WIDTH=2 instance ----------------
  logic [1:0] a2, b2, sum2;
  logic       c2, busy2, done2, pass2, fv_valid2;
  logic [4:0] err2;
  logic [3:0] fv2;
  state_t     st2;

  assign {c2, sum2} = {1'b0, a2} + {1'b0, b2};

  adder_bist #(.WIDTH(2), .SETTLE_CYCLES(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .dut_a(a2), .dut_b(b2), .dut_sum(sum2), .dut_c_out(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv_valid2), .fail_vector(fv2), .fsm_state(st2)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  int edge_n = 0;

  // Advance to the falling edge after rising edge k of the current run.
  task automatic step_to(input int k);
    while (edge_n < k) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  // start is sampled at the edge called edge 0; returns at the falling
  // edge just after it.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edge_n = 0;
  endtask

  task automatic pulse_start2();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    edge_n = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({dut_b, dut_a} !== 2'b00) $display("FAIL reset_vec got %b want 00", {dut_b, dut_a}); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b want 0", pass); else passed++;
    checks++; if (err_count !== 3'd0) $display("FAIL reset_err got %0d want 0", err_count); else passed++;
    checks++; if (fail_valid !== 1'b0) $display("FAIL reset_fvalid got %b want 0", fail_valid); else passed++;
    checks++; if (fail_vector !== 2'b00) $display("FAIL reset_fvec got %b want 00", fail_vector); else passed++;
    checks++; if (fsm_state !== IDLE) $display("FAIL reset_state got %0d want 0", fsm_state); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct_sweep();
    logic [1:0] exp_vec [4];
    exp_vec = '{2'd0, 2'd1, 2'd2, 2'd3};
    fault_mode = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) $display("FAIL ok_busy_e0 got %b want 1", busy); else passed++;
    for (int v = 0; v < 4; v++) begin
      step_to(3 * v + 1);
      checks++;
      if ({dut_b, dut_a} !== exp_vec[v])
        $display("FAIL ok_vec%0d got %b want %b", v, {dut_b, dut_a}, exp_vec[v]);
      else passed++;
    end
    step_to(11);
    checks++; if (done !== 1'b0) $display("FAIL ok_done_e11 got %b want 0", done); else passed++;
    step_to(12);
    checks++; if (done !== 1'b1) $display("FAIL ok_done_e12 got %b want 1", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ok_busy_e12 got %b want 0", busy); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL ok_pass got %b want 1", pass); else passed++;
    checks++; if (err_count !== 3'd0) $display("FAIL ok_err got %0d want 0", err_count); else passed++;
    checks++; if (fail_valid !== 1'b0) $display("FAIL ok_fvalid got %b want 0", fail_valid); else passed++;
    checks++; if ({dut_b, dut_a} !== 2'b11) $display("FAIL ok_vec_hold got %b want 11", {dut_b, dut_a}); else passed++;
  endtask

  task automatic test_carry_stuck();
    fault_mode = 1;
    pulse_start();
    step_to(12);
    checks++; if (done !== 1'b1) $display("FAIL cs_done got %b want 1", done); else passed++;
    checks++; if (err_count !== 3'd1) $display("FAIL cs_err got %0d want 1", err_count); else passed++;
    checks++; if (fail_vector !== 2'b11) $display("FAIL cs_fvec got %b want 11", fail_vector); else passed++;
    checks++; if (fail_valid !== 1'b1) $display("FAIL cs_fvalid got %b want 1", fail_valid); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL cs_pass got %b want 0", pass); else passed++;
    fault_mode = 0;
  endtask

  task automatic test_sum_inverted();
    fault_mode = 2;
    pulse_start();
    step_to(12);
    checks++; if (err_count !== 3'd4) $display("FAIL si_err got %0d want 4", err_count); else passed++;
    checks++; if (fail_vector !== 2'b00) $display("FAIL si_fvec got %b want 00", fail_vector); else passed++;
    checks++; if (fail_valid !== 1'b1) $display("FAIL si_fvalid got %b want 1", fail_valid); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL si_pass got %b want 0", pass); else passed++;
    fault_mode = 0;
  endtask

  task automatic test_reset_mid_run();
    fault_mode = 2;  // leaves nonzero partial results if reset were ignored
    pulse_start();
    step_to(4);
    reset = 1'b1;
    step_to(5);
    reset = 1'b0;
    checks++; if (fsm_state !== IDLE) $display("FAIL rm_state got %0d want 0", fsm_state); else passed++;
    checks++; if ({dut_b, dut_a} !== 2'b00) $display("FAIL rm_vec got %b want 00", {dut_b, dut_a}); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rm_busy got %b want 0", busy); else passed++;
    checks++; if (err_count !== 3'd0) $display("FAIL rm_err got %0d want 0", err_count); else passed++;
    checks++; if (fail_valid !== 1'b0) $display("FAIL rm_fvalid got %b want 0", fail_valid); else passed++;
    fault_mode = 0;
    pulse_start();
    step_to(11);
    checks++; if (done !== 1'b0) $display("FAIL rm_done_e11 got %b want 0", done); else passed++;
    step_to(12);
    checks++; if (done !== 1'b1) $display("FAIL rm_done_e12 got %b want 1", done); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL rm_pass got %b want 1", pass); else passed++;
  endtask

  task automatic test_start_ignored();
    fault_mode = 1;
    pulse_start();
    step_to(2);  start = 1'b1;
    step_to(3);  start = 1'b0;
    step_to(6);  start = 1'b1;
    step_to(7);  start = 1'b0;
    step_to(11);
    checks++; if (done !== 1'b0) $display("FAIL ig_done_e11 got %b want 0", done); else passed++;
    step_to(12);
    checks++; if (done !== 1'b1) $display("FAIL ig_done_e12 got %b want 1", done); else passed++;
    checks++; if (err_count !== 3'd1) $display("FAIL ig_err got %0d want 1", err_count); else passed++;
    // Restart from DONE: results clear on the start edge, then repeat.
    pulse_start();
    checks++; if (err_count !== 3'd0) $display("FAIL rs_err_clr got %0d want 0", err_count); else passed++;
    checks++; if (fail_valid !== 1'b0) $display("FAIL rs_fvalid_clr got %b want 0", fail_valid); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rs_done_clr got %b want 0", done); else passed++;
    step_to(12);
    checks++; if (done !== 1'b1) $display("FAIL rs_done got %b want 1", done); else passed++;
    checks++; if (err_count !== 3'd1) $display("FAIL rs_err got %0d want 1", err_count); else passed++;
    checks++; if (fail_vector !== 2'b11) $display("FAIL rs_fvec got %b want 11", fail_vector); else passed++;
    fault_mode = 0;
  endtask

  task automatic test_width2();
    pulse_start2();
    step_to(31);
    checks++; if (done2 !== 1'b0) $display("FAIL w2_done_e31 got %b want 0", done2); else passed++;
    step_to(32);
    checks++; if (done2 !== 1'b1) $display("FAIL w2_done_e32 got %b want 1", done2); else passed++;
    checks++; if (pass2 !== 1'b1) $display("FAIL w2_pass got %b want 1", pass2); else passed++;
    checks++; if (err2 !== 5'd0) $display("FAIL w2_err got %0d want 0", err2); else passed++;
    checks++; if ({b2, a2} !== 4'hF) $display("FAIL w2_vec_hold got %h want f", {b2, a2}); else passed++;
  endtask

  initial begin
    test_reset();
    test_correct_sweep();
    test_carry_stuck();
    test_sum_inverted();
    test_reset_mid_run();
    test_start_ignored();
    test_width2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
